// File: rtl/pipe_latch_if.sv
// Valid/ready bus carrying one pipeline entry (control bundle + payload).
// The master drives valid/ctrl/data; the slave drives ready.
interface pipe_latch_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_latch.sv
// Pipeline latch between two stages, with a stall-cycle counter and flush.
// Define PIPE_LATCH_SKID_EN for a two-entry skid buffer with registered in_ready;
// otherwise a single register whose in_ready is combinational from out_ready.
module pipe_latch #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_latch_if.slave      in_bus,
  pipe_latch_if.master     out_bus,
  output logic [CNT_W-1:0] stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic              in_fire;
  logic              out_fire;
  logic              out_valid;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;

  assign in_fire  = in_bus.valid & in_bus.ready & ~flush;
  assign out_fire = out_valid & out_bus.ready & ~flush;

`ifdef PIPE_LATCH_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_d = TWO;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        TWO:     if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid  = (state_q != EMPTY);
    in_ready_d = (state_d != TWO);
  end

  assign in_bus.ready = in_ready_q;

  // The main register always holds the oldest entry; the skid register only fills
  // when an entry arrives while the main one is stalled.
  always_ff @(posedge clk) begin
    if ((state_q == EMPTY && in_fire) || (state_q == ONE && in_fire && out_fire)) begin
      main_data_q <= in_bus.data;
      main_ctrl_q <= in_bus.ctrl;
    end else if (state_q == TWO && out_fire) begin
      main_data_q <= skid_data_q;
      main_ctrl_q <= skid_ctrl_q;
    end
    if (state_q == ONE && in_fire && !out_fire) begin
      skid_data_q <= in_bus.data;
      skid_ctrl_q <= in_bus.ctrl;
    end
  end
`else
  logic valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (flush)         valid_d = 1'b0;
    else if (in_fire)  valid_d = 1'b1;
    else if (out_fire) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  assign out_valid    = valid_q;
  assign in_bus.ready = ~rst & (~valid_q | out_bus.ready);

  always_ff @(posedge clk) begin
    if (in_fire) begin
      main_data_q <= in_bus.data;
      main_ctrl_q <= in_bus.ctrl;
    end
  end
`endif

  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_bus.ready && !flush) stall_d = sat_inc(stall_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

  // Bubbles must never carry reg_write/mem_to_reg downstream.
  assign out_bus.valid = out_valid;
  assign out_bus.ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_bus.data  = main_data_q;

endmodule
